qspi_flash_op_seq: RTL and testbench



---
 rtl/qspi_flash_op_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_qspi_flash_op_seq.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_op_seq.sv
// Flash erase sequencer: issues WREN, the selected erase instruction, then polls RDSR
// until WIP clears or the poll budget runs out. Owns the command channel for the whole
// operation and reports done/err/last status byte back to the CSR block.
module qspi_flash_op_seq #(
    parameter int unsigned POLL_GAP   = 64,
    parameter int unsigned MAX_POLLS  = 16'hFFFF,
    parameter logic [7:0]  INST_WREN  = 8'h06,
    parameter logic [7:0]  INST_RDSR  = 8'h05,
    parameter logic [7:0]  INST_SER   = 8'h20,
    parameter logic [7:0]  INST_BER32 = 8'h52,
    parameter logic [7:0]  INST_BER64 = 8'hD8,
    parameter logic [7:0]  INST_CER   = 8'hC7
) (
    input  logic        clock,
    input  logic        rst_n,

    // CSR side
    input  logic        io_op_start,
    input  logic [1:0]  io_op_type,
    input  logic [23:0] io_op_addr,
    output logic        io_op_busy,
    output logic        io_op_done,
    output logic        io_op_err,
    output logic [7:0]  io_op_status,

    // Command channel to the QSPI controller
    output logic        io_seq_req_valid,
    input  logic        io_seq_req_ready,
    output logic [7:0]  io_seq_req_inst,
    output logic [23:0] io_seq_req_addr,
    output logic [7:0]  io_seq_req_data_size,
    output logic [7:0]  io_seq_req_data_burstlen,
    input  logic        io_seq_rsp_valid,
    input  logic [7:0]  io_seq_rsp_data
);

    localparam int unsigned      GapW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GapW-1:0]  GapLast   = GapW'(POLL_GAP - 1);
    localparam logic [15:0]      PollLimit = 16'(MAX_POLLS);

    localparam logic [1:0] OpSer   = 2'd0;
    localparam logic [1:0] OpBer32 = 2'd1;
    localparam logic [1:0] OpBer64 = 2'd2;
    localparam logic [1:0] OpCer   = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StWrenReq,
        StWrenWait,
        StErsReq,
        StErsWait,
        StGap,
        StRdsrReq,
        StRdsrWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [23:0]       addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        status_q, status_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]       poll_inc;

    // Saturating increment: the timeout check fires long before this could wrap.
    assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation context, poll/gap counters and software-visible status.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            type_q     <= OpSer;
            addr_q     <= 24'h0;
            err_q      <= 1'b0;
            status_q   <= 8'h00;
            poll_cnt_q <= 16'h0;
            gap_cnt_q  <= '0;
        end else begin
            type_q     <= type_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            status_q   <= status_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state and datapath update; responses outside the WAIT states fall through.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        err_d      = err_q;
        status_d   = status_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (io_op_start) begin
                    state_d    = StWrenReq;
                    type_d     = io_op_type;
                    addr_d     = io_op_addr;
                    err_d      = 1'b0;
                    poll_cnt_d = 16'h0;
                end
            end
            // valid is decoded high in every REQ state, so ready alone completes it
            StWrenReq: begin
                if (io_seq_req_ready) begin
                    state_d = StWrenWait;
                end
            end
            StWrenWait: begin
                if (io_seq_rsp_valid) begin
                    state_d = StErsReq;
                end
            end
            StErsReq: begin
                if (io_seq_req_ready) begin
                    state_d = StErsWait;
                end
            end
            StErsWait: begin
                if (io_seq_rsp_valid) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StRdsrReq;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StRdsrReq: begin
                if (io_seq_req_ready) begin
                    state_d = StRdsrWait;
                end
            end
            StRdsrWait: begin
                if (io_seq_rsp_valid) begin
                    status_d   = io_seq_rsp_data;
                    poll_cnt_d = poll_inc;
                    if (!io_seq_rsp_data[0]) begin
                        state_d = StDone;
                    end else if (poll_inc >= PollLimit) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only; payload is held constant per REQ state.
    always_comb begin
        io_seq_req_valid         = 1'b0;
        io_seq_req_inst          = 8'h00;
        io_seq_req_addr          = 24'h0;
        io_seq_req_data_size     = 8'h00;
        io_seq_req_data_burstlen = 8'h00;
        io_op_busy               = (state_q != StIdle);
        io_op_done               = (state_q == StDone);
        io_op_err                = err_q;
        io_op_status             = status_q;

        unique case (state_q)
            StWrenReq: begin
                io_seq_req_valid = 1'b1;
                io_seq_req_inst  = INST_WREN;
            end
            StErsReq: begin
                io_seq_req_valid = 1'b1;
                unique case (type_q)
                    OpSer: begin
                        io_seq_req_inst = INST_SER;
                        io_seq_req_addr = addr_q;
                    end
                    OpBer32: begin
                        io_seq_req_inst = INST_BER32;
                        io_seq_req_addr = addr_q;
                    end
                    OpBer64: begin
                        io_seq_req_inst = INST_BER64;
                        io_seq_req_addr = addr_q;
                    end
                    OpCer: begin
                        // chip erase carries no address
                        io_seq_req_inst = INST_CER;
                        io_seq_req_addr = 24'h0;
                    end
                endcase
            end
            StRdsrReq: begin
                io_seq_req_valid         = 1'b1;
                io_seq_req_inst          = INST_RDSR;
                io_seq_req_data_burstlen = 8'h01;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_qspi_flash_op_seq.sv
// Bench for qspi_flash_op_seq: a randomised controller model answers requests, and each
// operation is checked against a request list computed from the erase sequence rules.
module tb_qspi_flash_op_seq;

    localparam int unsigned PollGap  = 4;
    localparam int unsigned MaxPolls = 4;

    logic        clock;
    logic        rst_n;
    logic        io_op_start;
    logic [1:0]  io_op_type;
    logic [23:0] io_op_addr;
    logic        io_op_busy;
    logic        io_op_done;
    logic        io_op_err;
    logic [7:0]  io_op_status;
    logic        io_seq_req_valid;
    logic        io_seq_req_ready;
    logic [7:0]  io_seq_req_inst;
    logic [23:0] io_seq_req_addr;
    logic [7:0]  io_seq_req_data_size;
    logic [7:0]  io_seq_req_data_burstlen;
    logic        io_seq_rsp_valid;
    logic [7:0]  io_seq_rsp_data;

    int tests;
    int fails;

    // controller model controls and observations
    int          ready_mode;    // 0: always ready, 1: random, 2: hold BER64 off for 10 cycles
    bit          spurious_en;
    logic [7:0]  stat_q[$];
    logic [7:0]  plan[$];
    logic [7:0]  rec_inst[$];
    logic [23:0] rec_addr[$];
    logic [7:0]  rec_bl[$];
    int          stable_err;
    int          timing_err;
    int          proto_err;
    int          hold_cnt;
    bit          pend;
    int          pend_dly;
    logic [7:0]  pend_data;
    bit          rdsr_outstanding;
    int          cyc;
    int          last_evt;
    logic        prev_valid;
    logic        prev_ready;
    logic [7:0]  prev_inst;
    logic [23:0] prev_addr;
    logic [7:0]  prev_bl;

    // reference expectations
    logic [7:0]  exp_inst[$];
    logic [23:0] exp_addr[$];
    logic [7:0]  exp_bl[$];
    logic        exp_err;
    logic [7:0]  exp_status;

    qspi_flash_op_seq #(
        .POLL_GAP  (PollGap),
        .MAX_POLLS (MaxPolls)
    ) dut (
        .clock                    (clock),
        .rst_n                    (rst_n),
        .io_op_start              (io_op_start),
        .io_op_type               (io_op_type),
        .io_op_addr               (io_op_addr),
        .io_op_busy               (io_op_busy),
        .io_op_done               (io_op_done),
        .io_op_err                (io_op_err),
        .io_op_status             (io_op_status),
        .io_seq_req_valid         (io_seq_req_valid),
        .io_seq_req_ready         (io_seq_req_ready),
        .io_seq_req_inst          (io_seq_req_inst),
        .io_seq_req_addr          (io_seq_req_addr),
        .io_seq_req_data_size     (io_seq_req_data_size),
        .io_seq_req_data_burstlen (io_seq_req_data_burstlen),
        .io_seq_rsp_valid         (io_seq_rsp_valid),
        .io_seq_rsp_data          (io_seq_rsp_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Controller model and protocol monitor; runs just after each falling edge.
    initial begin
        int exp_d;
        io_seq_req_ready = 1'b0;
        io_seq_rsp_valid = 1'b0;
        io_seq_rsp_data  = 8'h00;
        pend = 0; pend_dly = 0; pend_data = 8'h00; rdsr_outstanding = 0;
        cyc = 0; last_evt = 0; hold_cnt = 0;
        stable_err = 0; timing_err = 0; proto_err = 0;
        prev_valid = 1'b0; prev_ready = 1'b0;
        prev_inst = 8'h00; prev_addr = 24'h0; prev_bl = 8'h00;
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (rst_n !== 1'b1) begin
                pend = 0;
                rdsr_outstanding = 0;
                io_seq_rsp_valid = 1'b0;
                io_seq_req_ready = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (io_op_start && !io_op_busy) last_evt = cyc;
                // first valid cycle: 1 cycle after start/WREN response, gap+1 after a poll
                if (io_seq_req_valid && !prev_valid) begin
                    exp_d = (io_seq_req_inst == 8'h05) ? int'(PollGap) + 1 : 1;
                    if (cyc - last_evt != exp_d) timing_err++;
                end
                if (prev_valid && !prev_ready) begin
                    if (!io_seq_req_valid || io_seq_req_inst != prev_inst ||
                        io_seq_req_addr != prev_addr || io_seq_req_data_burstlen != prev_bl)
                        stable_err++;
                end
                if (prev_valid && prev_ready && io_seq_req_valid) proto_err++;
                if (io_seq_req_valid && io_seq_req_data_size != 8'h00) proto_err++;

                io_seq_rsp_valid = 1'b0;
                if (pend) begin
                    if (pend_dly == 0) begin
                        io_seq_rsp_valid = 1'b1;
                        io_seq_rsp_data  = pend_data;
                        pend = 0;
                        rdsr_outstanding = 0;
                        last_evt = cyc;
                    end else begin
                        pend_dly--;
                    end
                end else if (spurious_en && io_op_busy && $urandom_range(0, 2) == 0) begin
                    io_seq_rsp_valid = 1'b1;
                    io_seq_rsp_data  = 8'h00;
                end

                case (ready_mode)
                    0: io_seq_req_ready = 1'b1;
                    1: io_seq_req_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (io_seq_req_valid && io_seq_req_inst == 8'hD8 && hold_cnt < 10) begin
                            io_seq_req_ready = 1'b0;
                            hold_cnt++;
                        end else begin
                            io_seq_req_ready = 1'b1;
                        end
                    end
                endcase

                if (io_seq_req_valid && io_seq_req_ready) begin
                    rec_inst.push_back(io_seq_req_inst);
                    rec_addr.push_back(io_seq_req_addr);
                    rec_bl.push_back(io_seq_req_data_burstlen);
                    pend = 1;
                    pend_dly = $urandom_range(0, 3);
                    if (io_seq_req_inst == 8'h05) begin
                        pend_data = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
                        rdsr_outstanding = 1;
                    end else begin
                        pend_data = 8'($urandom);
                    end
                end
                prev_valid = io_seq_req_valid;
                prev_ready = io_seq_req_ready;
                prev_inst  = io_seq_req_inst;
                prev_addr  = io_seq_req_addr;
                prev_bl    = io_seq_req_data_burstlen;
            end
        end
    end

    // Expected request list for one operation, built from the sequence rules.
    task automatic build_model(input logic [1:0] t, input logic [23:0] a);
        logic [7:0] s;
        int polls;
        exp_inst = {}; exp_addr = {}; exp_bl = {};
        exp_inst.push_back(8'h06); exp_addr.push_back(24'h0); exp_bl.push_back(8'h00);
        case (t)
            2'd0: exp_inst.push_back(8'h20);
            2'd1: exp_inst.push_back(8'h52);
            2'd2: exp_inst.push_back(8'hD8);
            default: exp_inst.push_back(8'hC7);
        endcase
        exp_addr.push_back((t == 2'd3) ? 24'h0 : a);
        exp_bl.push_back(8'h00);
        polls = 0;
        exp_err = 1'b0;
        exp_status = 8'h00;
        forever begin
            s = (polls < plan.size()) ? plan[polls] : 8'h00;
            exp_inst.push_back(8'h05); exp_addr.push_back(24'h0); exp_bl.push_back(8'h01);
            polls++;
            exp_status = s;
            if (s[0] == 1'b0) break;
            if (polls == int'(MaxPolls)) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst_n = 1'b0;
        io_op_start = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    // Runs one operation end to end and compares it with the model.
    task automatic run_op(input logic [1:0] t, input logic [23:0] a, input bit noise);
        bit got;
        build_model(t, a);
        stat_q = plan;
        rec_inst = {}; rec_addr = {}; rec_bl = {};
        stable_err = 0; timing_err = 0; proto_err = 0;
        @(negedge clock);
        io_op_start = 1'b1;
        io_op_type  = t;
        io_op_addr  = a;
        @(negedge clock);
        io_op_start = 1'b0;
        tests++;
        if ({io_op_busy, io_op_err, io_seq_req_valid} !== 3'b101) begin
            fails++;
            $display("FAIL accept: busy/err/valid got %b required 101", {io_op_busy, io_op_err,
                     io_seq_req_valid});
        end
        got = 0;
        for (int n = 0; n < 3000; n++) begin
            if (io_op_done === 1'b1) begin
                got = 1;
                break;
            end
            if (noise && $urandom_range(0, 3) == 0) begin
                io_op_start = 1'b1;
                io_op_type  = 2'($urandom);
                io_op_addr  = 24'($urandom);
            end
            @(negedge clock);
            io_op_start = 1'b0;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL done_timeout: got no done within 3000 cycles, required done pulse");
            apply_reset();
            return;
        end
        tests++;
        if (io_op_err !== exp_err) begin
            fails++;
            $display("FAIL err: got %b required %b", io_op_err, exp_err);
        end
        tests++;
        if (io_op_status !== exp_status) begin
            fails++;
            $display("FAIL status: got %h required %h", io_op_status, exp_status);
        end
        tests++;
        if (io_op_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_done: got %b required 1", io_op_busy);
        end
        @(negedge clock);
        tests++;
        if ({io_op_done, io_op_busy} !== 2'b00) begin
            fails++;
            $display("FAIL done_one_cycle: done/busy got %b required 00", {io_op_done, io_op_busy});
        end
        tests++;
        if (rec_inst.size() != exp_inst.size()) begin
            fails++;
            $display("FAIL req_count: got %0d required %0d", rec_inst.size(), exp_inst.size());
        end else begin
            for (int i = 0; i < exp_inst.size(); i++) begin
                tests++;
                if (rec_inst[i] !== exp_inst[i] || rec_addr[i] !== exp_addr[i] ||
                    rec_bl[i] !== exp_bl[i]) begin
                    fails++;
                    $display("FAIL req[%0d]: got %h/%h/%h required %h/%h/%h", i, rec_inst[i],
                             rec_addr[i], rec_bl[i], exp_inst[i], exp_addr[i], exp_bl[i]);
                end
            end
        end
        tests++;
        if (stable_err != 0 || timing_err != 0 || proto_err != 0) begin
            fails++;
            $display("FAIL protocol: got stable/timing/proto %0d/%0d/%0d required 0/0/0",
                     stable_err, timing_err, proto_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io_op_start = 1'b0; io_op_type = 2'd0; io_op_addr = 24'h0;
        ready_mode = 0; spurious_en = 0;
        repeat (3) @(negedge clock);
        tests++;
        if ({io_op_busy, io_op_done, io_op_err, io_seq_req_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000", {io_op_busy, io_op_done, io_op_err,
                     io_seq_req_valid});
        end
        tests++;
        if (io_op_status !== 8'h00 || io_seq_req_inst !== 8'h00) begin
            fails++;
            $display("FAIL reset_status_inst: got %h/%h required 00/00", io_op_status,
                     io_seq_req_inst);
        end
        tests++;
        if (io_seq_req_addr !== 24'h0 || io_seq_req_data_size !== 8'h00 ||
            io_seq_req_data_burstlen !== 8'h00) begin
            fails++;
            $display("FAIL reset_payload: got %h/%h/%h required 000000/00/00", io_seq_req_addr,
                     io_seq_req_data_size, io_seq_req_data_burstlen);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if ({io_op_busy, io_seq_req_valid} !== 2'b00) begin
            fails++;
            $display("FAIL idle_after_reset: busy/valid got %b required 00", {io_op_busy,
                     io_seq_req_valid});
        end
    endtask

    task automatic test_ser();
        ready_mode = 0;
        plan = {8'h00};
        run_op(2'd0, 24'h012345, 0);
    endtask

    task automatic test_cer_poll();
        ready_mode = 1;
        plan = {8'h03, 8'h03, 8'h00};
        run_op(2'd3, 24'($urandom), 0);
    endtask

    task automatic test_timeout();
        ready_mode = 1;
        plan = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        run_op(2'd1, 24'($urandom), 0);
        tests++;
        if (io_op_err !== 1'b1) begin
            fails++;
            $display("FAIL err_held_idle: got %b required 1", io_op_err);
        end
        // the accept check inside run_op confirms err clears on the next start
        plan = {8'h00};
        run_op(2'd0, 24'($urandom), 0);
    endtask

    task automatic test_ready_hold();
        ready_mode = 2;
        hold_cnt = 0;
        plan = {8'h01, 8'h00};
        run_op(2'd2, 24'hABCDEF, 0);
        tests++;
        if (hold_cnt != 10) begin
            fails++;
            $display("FAIL hold_cycles: got %0d required 10", hold_cnt);
        end
    endtask

    task automatic test_busy_noise();
        ready_mode = 1;
        spurious_en = 1;
        plan = {8'h05, 8'h01, 8'h00};
        run_op(2'($urandom), 24'($urandom), 1);
        spurious_en = 0;
    endtask

    task automatic test_random();
        int len;
        for (int k = 0; k < 6; k++) begin
            ready_mode  = $urandom_range(0, 1);
            spurious_en = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            plan = {};
            for (int j = 0; j < len; j++) plan.push_back(8'($urandom));
            run_op(2'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));
        end
        spurious_en = 0;
    endtask

    task automatic test_reset_mid();
        bit got;
        ready_mode = 0;
        plan = {8'h01, 8'h01, 8'h01, 8'h01};
        stat_q = plan;
        @(negedge clock);
        io_op_start = 1'b1;
        io_op_type  = 2'd0;
        io_op_addr  = 24'h5A5A5A;
        @(negedge clock);
        io_op_start = 1'b0;
        got = 0;
        for (int n = 0; n < 500; n++) begin
            if (rdsr_outstanding) begin
                got = 1;
                break;
            end
            @(negedge clock);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL reach_rdsr_wait: got no RDSR outstanding, required one");
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({io_op_busy, io_op_done, io_op_err, io_seq_req_valid} !== 4'b0000 ||
            io_op_status !== 8'h00 || io_seq_req_inst !== 8'h00 || io_seq_req_addr !== 24'h0) begin
            fails++;
            $display("FAIL mid_reset: flags %b status %h inst %h addr %h required 0000/00/00/000000",
                     {io_op_busy, io_op_done, io_op_err, io_seq_req_valid}, io_op_status,
                     io_seq_req_inst, io_seq_req_addr);
        end
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        plan = {8'h00};
        run_op(2'd1, 24'h00F00D, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_ser();
        test_cer_poll();
        test_timeout();
        test_ready_hold();
        test_busy_noise();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
